// File: rtl/sparc_ifu_thrfsm_pkg.sv
// Shared thread-state encodings and helpers for the multi-thread IFU thread FSM.
package sparc_ifu_thrfsm_pkg;

  localparam int STATE_W = 5;

  localparam logic [4:0] ST_IDLE     = 5'b00000;
  localparam logic [4:0] ST_HALT     = 5'b00010;
  localparam logic [4:0] ST_WAIT     = 5'b00001;
  localparam logic [4:0] ST_RDY      = 5'b11001;
  localparam logic [4:0] ST_RUN      = 5'b00101;
  localparam logic [4:0] ST_SPEC_RDY = 5'b10011;
  localparam logic [4:0] ST_SPEC_RUN = 5'b00111;

  function automatic logic is_running(logic [STATE_W-1:0] s);
    return (s == ST_RUN) || (s == ST_SPEC_RUN);
  endfunction

  function automatic logic is_ready(logic [STATE_W-1:0] s);
    return (s == ST_RDY) || (s == ST_SPEC_RDY);
  endfunction

endpackage

// File: rtl/sparc_ifu_thrfsm_if.sv
// Per-thread event inputs, debug overwrite and state/schedule outputs of the thread FSM array.
interface sparc_ifu_thrfsm_if #(
  parameter int NTHR = 4,
  parameter int TIDW = 2
);
  import sparc_ifu_thrfsm_pkg::*;

  logic [NTHR-1:0]         completion;
  logic [NTHR-1:0]         stall;
  logic [NTHR-1:0]         spec_ld;
  logic [NTHR-1:0]         ldhit;
  logic [NTHR-1:0]         int_activate;
  logic [NTHR-1:0]         halt_thread;
  logic [NTHR-1:0]         start_thread;
  logic [NTHR-1:0]         nuke_thread;
  logic [NTHR-1:0]         thaw_thread;
  logic [NTHR-1:0]         rst_thread;
  logic                    sw_cond;
  logic                    switch_req;
  logic                    dbg_wr_en;
  logic [TIDW-1:0]         dbg_wr_tid;
  logic [STATE_W-1:0]      dbg_wr_data;
  logic [STATE_W*NTHR-1:0] thr_state;
  logic [STATE_W*NTHR-1:0] thr_nstate;
  logic                    sched_vld;
  logic [TIDW-1:0]         sched_tid;
  logic [NTHR-1:0]         wdog_expired;

  modport master (
    output completion, stall, spec_ld, ldhit, int_activate, halt_thread, start_thread,
           nuke_thread, thaw_thread, rst_thread, sw_cond, switch_req,
           dbg_wr_en, dbg_wr_tid, dbg_wr_data,
    input  thr_state, thr_nstate, sched_vld, sched_tid, wdog_expired
  );

  modport slave (
    input  completion, stall, spec_ld, ldhit, int_activate, halt_thread, start_thread,
           nuke_thread, thaw_thread, rst_thread, sw_cond, switch_req,
           dbg_wr_en, dbg_wr_tid, dbg_wr_data,
    output thr_state, thr_nstate, sched_vld, sched_tid, wdog_expired
  );

endinterface

// File: rtl/sparc_ifu_thrfsm_core.sv
// One thread's next-state logic and state register; optional WAIT watchdog under THRFSM_WDOG_EN.
module sparc_ifu_thrfsm_core
  import sparc_ifu_thrfsm_pkg::*;
`ifdef THRFSM_WDOG_EN
#(
  parameter int WDOG_W = 10
)
`endif
(
  input  logic               clk,
  input  logic               reset,
  input  logic               completion,
  input  logic               stall,
  input  logic               spec_ld,
  input  logic               ldhit,
  input  logic               int_activate,
  input  logic               halt_thread,
  input  logic               start_thread,
  input  logic               nuke_thread,
  input  logic               thaw_thread,
  input  logic               rst_thread,
  input  logic               sw_cond,
  input  logic               schedule,
  input  logic               switch_out,
  input  logic               dbg_wr,
  input  logic [STATE_W-1:0] dbg_data,
  output logic [STATE_W-1:0] state_q,
  output logic [STATE_W-1:0] state_d,
  output logic               wdog_expired
);

  logic [STATE_W-1:0] fsm_d;

  always_comb begin
    fsm_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (rst_thread || thaw_thread)       fsm_d = ST_WAIT;
        else if (start_thread)               fsm_d = ST_RDY;
      end
      ST_HALT: begin
        if (nuke_thread)                     fsm_d = ST_IDLE;
        else if (rst_thread || thaw_thread)  fsm_d = ST_WAIT;
        else if (int_activate || start_thread) fsm_d = ST_RDY;
      end
      ST_RDY: begin
        if (stall)                           fsm_d = ST_WAIT;
        else if (schedule)                   fsm_d = ST_RUN;
      end
      ST_RUN: begin
        if (stall || sw_cond)                fsm_d = ST_WAIT;
        else if (switch_out)                 fsm_d = ST_RDY;
      end
      ST_WAIT: begin
        if (nuke_thread)                     fsm_d = ST_IDLE;
        else if (halt_thread)                fsm_d = ST_HALT;
        else if (stall)                      fsm_d = ST_WAIT;
        else if (spec_ld)                    fsm_d = ST_SPEC_RDY;
        else if (completion)                 fsm_d = ST_RDY;
      end
      ST_SPEC_RDY: begin
        if (stall)                           fsm_d = ST_WAIT;
        else if (schedule)                   fsm_d = ldhit ? ST_RUN : ST_SPEC_RUN;
        else if (ldhit)                      fsm_d = ST_RDY;
      end
      ST_SPEC_RUN: begin
        if (stall || sw_cond)                fsm_d = ST_WAIT;
        else if (ldhit)                      fsm_d = switch_out ? ST_RDY : ST_RUN;
        else if (switch_out)                 fsm_d = ST_SPEC_RDY;
      end
      // Unknown encodings recover without ever stalling the thread forever.
      default:                               fsm_d = rst_thread ? ST_WAIT : ST_IDLE;
    endcase
    state_d = dbg_wr ? dbg_data : fsm_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

`ifdef THRFSM_WDOG_EN
  localparam logic [WDOG_W-1:0] WDOG_MAX = '1;

  logic [WDOG_W-1:0] wcnt_q, wcnt_d;

  always_comb begin
    wcnt_d = wcnt_q;
    if (dbg_wr || (state_q != ST_WAIT)) wcnt_d = '0;
    else if (wcnt_q != WDOG_MAX)        wcnt_d = wcnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wcnt_q <= '0;
    else       wcnt_q <= wcnt_d;
  end

  // Fires during the cycle in which the count reaches all-ones, then stays quiet while saturated.
  assign wdog_expired = (state_q == ST_WAIT) && (wcnt_q == WDOG_MAX - 1'b1);
`else
  assign wdog_expired = 1'b0;
`endif

endmodule

// File: rtl/sparc_ifu_thrfsm_array.sv
// NTHR thread FSMs plus round-robin switch-in picker; THRFSM_WDOG_EN adds per-thread WAIT watchdogs.
module sparc_ifu_thrfsm_array
  import sparc_ifu_thrfsm_pkg::*;
#(
  parameter int NTHR   = 4,
  parameter int TIDW   = 2,
  parameter int WDOG_W = 10
) (
  input logic               clk,
  input logic               reset,
  sparc_ifu_thrfsm_if.slave bus
);

  // A misconfigured build never grants, so the error is visible instead of silently aliasing tids.
  localparam bit CFG_OK = (TIDW == $clog2(NTHR)) && (NTHR >= 2) && (NTHR <= 8) && (WDOG_W >= 2);

  logic [NTHR-1:0][STATE_W-1:0] state_q, state_d;
  logic [NTHR-1:0]              running, eligible, schedule, switch_out, wdog_expired;
  logic [TIDW-1:0]              rr_ptr_q, rr_ptr_d, sched_tid;
  logic                         sched_vld;

  for (genvar i = 0; i < NTHR; i++) begin : g_thr
    logic dbg_hit;
    assign dbg_hit       = bus.dbg_wr_en && (bus.dbg_wr_tid == TIDW'(i));
    assign running[i]    = is_running(state_q[i]);
    assign eligible[i]   = is_ready(state_q[i]) && !bus.stall[i];
    assign switch_out[i] = bus.switch_req && running[i];

    sparc_ifu_thrfsm_core
`ifdef THRFSM_WDOG_EN
      #(.WDOG_W(WDOG_W))
`endif
      u_core (
        .clk          (clk),
        .reset        (reset),
        .completion   (bus.completion[i]),
        .stall        (bus.stall[i]),
        .spec_ld      (bus.spec_ld[i]),
        .ldhit        (bus.ldhit[i]),
        .int_activate (bus.int_activate[i]),
        .halt_thread  (bus.halt_thread[i]),
        .start_thread (bus.start_thread[i]),
        .nuke_thread  (bus.nuke_thread[i]),
        .thaw_thread  (bus.thaw_thread[i]),
        .rst_thread   (bus.rst_thread[i]),
        .sw_cond      (bus.sw_cond && running[i]),
        .schedule     (schedule[i]),
        .switch_out   (switch_out[i]),
        .dbg_wr       (dbg_hit),
        .dbg_data     (bus.dbg_wr_data),
        .state_q      (state_q[i]),
        .state_d      (state_d[i]),
        .wdog_expired (wdog_expired[i])
      );
  end

  always_comb begin
    sched_vld = 1'b0;
    sched_tid = '0;
    rr_ptr_d  = rr_ptr_q;
    if (CFG_OK && (!(|running) || bus.switch_req)) begin
      for (int k = 1; k <= NTHR; k++) begin
        if (!sched_vld && eligible[(int'(rr_ptr_q) + k) % NTHR]) begin
          sched_vld = 1'b1;
          sched_tid = TIDW'((int'(rr_ptr_q) + k) % NTHR);
        end
      end
    end
    for (int i = 0; i < NTHR; i++) schedule[i] = sched_vld && (sched_tid == TIDW'(i));
    if (sched_vld) rr_ptr_d = sched_tid;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rr_ptr_q <= TIDW'(NTHR - 1);
    else       rr_ptr_q <= rr_ptr_d;
  end

  assign bus.thr_state    = state_q;
  assign bus.thr_nstate   = state_d;
  assign bus.sched_vld    = sched_vld;
  assign bus.sched_tid    = sched_tid;
  assign bus.wdog_expired = wdog_expired;

endmodule

// File: doc/sparc_ifu_thrfsm_array.md
Name: sparc_ifu_thrfsm_array

Overview:
- Parametrised successor to the single-thread IFU thread FSM: NTHR per-thread state machines in one block, plus an integrated round-robin switch-in picker.
- The picker generates `schedule` and `switch_out` internally, so FCL no longer computes them per thread.
- Sits in the IFU between the switch logic and FCL.
- Also provides a per-thread debug/JTAG state overwrite port.

Parameters:
- NTHR, 4, number of hardware threads (2..8).
- TIDW, 2, thread-id width; must equal clog2(NTHR).
- WDOG_W, 10, WAIT-watchdog counter width (used only with the optional feature).

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- completion  in  NTHR  awaited op complete, per thread
- stall  in  NTHR  ldmiss/imiss/trap stall, per thread
- spec_ld  in  NTHR  speculative switch-in request
- ldhit  in  NTHR  speculation resolved correct
- int_activate  in  NTHR  interrupt wake from HALT
- halt_thread  in  NTHR  park thread in HALT
- start_thread  in  NTHR  start from IDLE/HALT
- nuke_thread  in  NTHR  kill thread to IDLE
- thaw_thread  in  NTHR  thaw to WAIT
- rst_thread  in  NTHR  thread reset to WAIT
- sw_cond  in  1  running thread must wait for completion
- switch_req  in  1  switch out the running thread this cycle
- dbg_wr_en  in  1  debug state overwrite strobe
- dbg_wr_tid  in  TIDW  target thread of the overwrite
- dbg_wr_data  in  5  state value to write
- thr_state  out  5*NTHR  current state; thread i occupies bits [5i+4:5i]
- thr_nstate  out  5*NTHR  next state (combinational)
- sched_vld  out  1  a thread is switched in this cycle
- sched_tid  out  TIDW  id of the switched-in thread
- wdog_expired  out  NTHR  WAIT timeout pulse (feature only; tied 0 otherwise)

Behaviour:
- State encodings:
  - IDLE 00000, HALT 00010, WAIT 00001, RDY 11001, RUN 00101, SPEC_RDY 10011, SPEC_RUN 00111.
- Per-thread transitions, in priority order per state:
  - IDLE: rst|thaw -> WAIT; start -> RDY.
  - HALT: nuke -> IDLE; rst|thaw -> WAIT; int_activate|start -> RDY.
  - RDY: stall -> WAIT; schedule -> RUN.
  - RUN: stall|sw_cond -> WAIT; switch_out -> RDY.
  - WAIT: nuke -> IDLE; halt -> HALT; stall -> WAIT; spec_ld -> SPEC_RDY; completion -> RDY.
  - SPEC_RDY: stall -> WAIT; schedule&~ldhit -> SPEC_RUN; schedule&ldhit -> RUN; ldhit -> RDY.
  - SPEC_RUN: stall|sw_cond -> WAIT; ldhit&switch_out -> RDY; ldhit -> RUN; switch_out -> SPEC_RDY.
  - In all cases, no matching condition -> hold.
- Illegal state: rst -> WAIT; else nuke -> WAIT... no: nuke -> IDLE; otherwise force IDLE. Never halts simulation. Synthesis sees the same recovery logic.
- Running thread:
  - A thread is running when in RUN or SPEC_RUN; at most one thread runs at a time.
  - switch_out[i] = switch_req & running[i].
  - sw_cond applies only to the running thread.
- Picker (combinational from registered state):
  - Eligible = RDY or SPEC_RDY, with no stall this cycle.
  - Picks only when no thread is running, or switch_req is high.
  - Search is round-robin starting at rr_ptr+1 mod NTHR.
  - Grant: schedule[g]=1, sched_vld=1, sched_tid=g; rr_ptr <= g on the next edge.
  - No eligible thread: sched_vld=0, sched_tid=0, rr_ptr holds.
  - Switch-out and switch-in in the same cycle is legal: the old thread goes to RDY or SPEC_RDY and is not eligible that cycle.
- Debug overwrite:
  - dbg_wr_en replaces next_state of thread dbg_wr_tid with dbg_wr_data at the next edge.
  - Takes priority over FSM events; other threads are unaffected.
  - dbg_wr_tid >= NTHR is ignored.
- Reset (asynchronous):
  - All states IDLE, rr_ptr = NTHR-1 (so thread 0 is searched first), watchdog counters 0.
  - Outputs: thr_state 0, sched_vld 0, wdog_expired 0.
  - Reset asserted mid-operation overrides everything immediately.
- Latency: a state update is visible on thr_state one cycle after the input event.

Optional Feature:
- THRFSM_WDOG_EN defined:
  - Per-thread WDOG_W-bit counter increments each cycle the thread is in WAIT.
  - Clears on leaving WAIT and on a debug write to that thread.
  - On reaching all-ones: wdog_expired[i] pulses for one cycle, and the counter saturates until WAIT is left.
  - The watchdog does not alter state.
- THRFSM_WDOG_EN undefined: no counters exist; wdog_expired is tied 0.

Decomposition:
- Package sparc_ifu_thrfsm_pkg: the seven state encodings, a state-width constant (5), and an is_running function.
- Sub-module sparc_ifu_thrfsm_core: one thread's next-state logic, state register, and optional watchdog; instantiated NTHR times via generate.
- Picker and rr_ptr live in the top module.

Test Plan:
- Reset, then start_thread=0001 -> next cycle thr_state[4:0]=11001; the following cycle sched_vld=1, sched_tid=0, thread 0 in RUN.
- All four threads RDY, switch_req held high -> grants rotate tid 1,2,3,0,1 on consecutive cycles; previous thread returns to RDY each cycle.
- Thread 2 in WAIT, spec_ld -> SPEC_RDY; scheduled with ldhit=0 -> SPEC_RUN; ldhit=1 next cycle -> RUN.
- Running thread 1 with stall=0010 and switch_req=1 in the same cycle -> thread 1 goes to WAIT; another RDY thread is granted.
- dbg_wr_en=1, tid=3, data=00010 while thread 3 is RUN and stall is high -> thr_state[19:15]=00010 (debug wins); dbg_wr_data=11111 -> next cycle the thread recovers to IDLE.
- With THRFSM_WDOG_EN and WDOG_W=4, thread 0 held in WAIT -> wdog_expired[0] pulses on the 15th WAIT cycle only; reset asserted mid-count clears the counter and state asynchronously.
